// File: rtl/classifier_head_pkg.sv
// Shared types and arithmetic helpers for the classifier back end.
package classifier_head_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, OUT, FIN} state_t;

    // Working width for saturating arithmetic; supports ACC_W up to 62.
    localparam int SAT_W = 64;
    localparam logic signed [SAT_W-1:0] SCORE_MIN = {1'b1, {(SAT_W-1){1'b0}}};

    // Callers sign-extend acc and bias to SAT_W and truncate the result back to acc_w.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] bias,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = acc + bias;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi)
            sum = hi;
        else if (sum < lo)
            sum = lo;
        return sum;
    endfunction

endpackage

// File: rtl/classifier_head_argmax_step.sv
// Combinational best/second/index update for one candidate score.
module argmax_step
    import classifier_head_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int IDX_W = 4
) (
    input  logic                    first,
    input  logic signed [ACC_W-1:0] cand,
    input  logic        [IDX_W-1:0] cand_idx,
    input  logic signed [ACC_W-1:0] best,
    input  logic signed [ACC_W-1:0] second,
    input  logic        [IDX_W-1:0] best_idx,
    output logic signed [ACC_W-1:0] best_nxt,
    output logic signed [ACC_W-1:0] second_nxt,
    output logic        [IDX_W-1:0] idx_nxt
);

    localparam logic signed [ACC_W-1:0] MIN_VAL = ACC_W'(sat_add(SCORE_MIN, '0, ACC_W));

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = best_idx;
        if (first) begin
            best_nxt   = cand;
            second_nxt = MIN_VAL;
            idx_nxt    = cand_idx;
        end else if (cand > best) begin
            second_nxt = best;
            best_nxt   = cand;
            idx_nxt    = cand_idx;
        end else if (cand > second) begin
            // Equal-to-best lands here, so a tie keeps the lower index with margin 0.
            second_nxt = cand;
        end
    end

endmodule

// File: rtl/classifier_head.sv
// Batched bias-add and serial arg-max over ROWS x NUM_CLASSES accumulator outputs,
// one class per cycle, with a valid/ready result port.
module classifier_head
    import classifier_head_pkg::*;
#(
    parameter int ACC_W       = 32,
    parameter int BIAS_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int ROWS        = 1,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [ACC_W-1:0]       acc_in [ROWS][NUM_CLASSES],
    input  logic signed [BIAS_W-1:0]      bias_in [NUM_CLASSES],
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(ROWS):0]         res_row,
    output logic [IDX_W-1:0]              res_class,
    output logic [NUM_CLASSES-1:0]        res_onehot,
    output logic [ACC_W-1:0]              res_score,
    output logic [ACC_W:0]                res_margin,
    output logic                          done
);

    localparam int ROW_W = $clog2(ROWS) + 1;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc_q  [ROWS][NUM_CLASSES];
    logic signed [BIAS_W-1:0] bias_q [NUM_CLASSES];
    logic [ROW_W-1:0]         row_q;
    logic [IDX_W-1:0]         cls_q;
    logic signed [ACC_W-1:0]  best_q, second_q, best_nxt, second_nxt;
    logic [IDX_W-1:0]         idx_q, idx_nxt;
    logic signed [ACC_W-1:0]  acc_sel, score;
    logic signed [BIAS_W-1:0] bias_sel;
    logic                     last_cls, last_row;

    assign last_cls  = (cls_q == IDX_W'(NUM_CLASSES - 1));
    assign last_row  = (row_q == ROW_W'(ROWS - 1));
    assign busy      = (state != IDLE);
    assign res_valid = (state == OUT);
    assign done      = (state == FIN);

    always_comb begin
        acc_sel  = '0;
        bias_sel = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < NUM_CLASSES; k++)
                if (row_q == ROW_W'(r) && cls_q == IDX_W'(k))
                    acc_sel = acc_q[r][k];
        for (int k = 0; k < NUM_CLASSES; k++)
            if (cls_q == IDX_W'(k))
                bias_sel = bias_q[k];
    end

    assign score = ACC_W'(sat_add(SAT_W'(acc_sel), SAT_W'(bias_sel), ACC_W));

    argmax_step #(.ACC_W(ACC_W), .IDX_W(IDX_W)) u_step (
        .first      (cls_q == '0),
        .cand       (score),
        .cand_idx   (cls_q),
        .best       (best_q),
        .second     (second_q),
        .best_idx   (idx_q),
        .best_nxt   (best_nxt),
        .second_nxt (second_nxt),
        .idx_nxt    (idx_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_cls) state_nxt = OUT;
            OUT:     if (res_ready) state_nxt = last_row ? FIN : SCAN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the captured matrix is plain storage gated by start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc_q  <= acc_in;
            bias_q <= bias_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row_q      <= '0;
            cls_q      <= '0;
            best_q     <= '0;
            second_q   <= '0;
            idx_q      <= '0;
            res_row    <= '0;
            res_class  <= '0;
            res_onehot <= '0;
            res_score  <= '0;
            res_margin <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    row_q <= '0;
                    cls_q <= '0;
                end
                SCAN: begin
                    best_q   <= best_nxt;
                    second_q <= second_nxt;
                    idx_q    <= idx_nxt;
                    cls_q    <= last_cls ? '0 : cls_q + 1'b1;
                    if (last_cls) begin
                        res_row    <= row_q;
                        res_class  <= idx_nxt;
                        res_onehot <= NUM_CLASSES'(1) << idx_nxt;
                        res_score  <= best_nxt;
                        res_margin <= {best_nxt[ACC_W-1], best_nxt}
                                    - {second_nxt[ACC_W-1], second_nxt};
                    end
                end
                OUT: if (res_ready && !last_row) begin
                    row_q <= row_q + 1'b1;
                    cls_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
